// File: rtl/seq_mult_ctrl_pkg.sv
// seq_mult_ctrl_pkg
//   Constants and state type shared by the sequential multiplier controller.
//   WIDTH is tied to the 8-bit ripple Adder and must not be changed.
//   CNT_W must be wide enough to hold ITER.
package seq_mult_ctrl_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ITER  = 8;

  // Counter value seen on the final shift-add iteration.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_ctrl_adder.sv
// Adder
//   8-bit ripple-carry adder used as the shared datapath adder.
//   Ports:
//     iData_a, iData_b : 8-bit addends
//     iC               : carry in
//     oData            : 8-bit sum
//     oData_C          : carry out
module Adder (
  output logic [7:0] oData,
  output logic       oData_C,
  input  logic [7:0] iData_a,
  input  logic [7:0] iData_b,
  input  logic       iC
);

  always_comb begin
    logic c;
    oData = '0;
    c     = iC;
    for (int i = 0; i < 8; i++) begin
      oData[i] = iData_a[i] ^ iData_b[i] ^ c;
      c        = (iData_a[i] & iData_b[i]) | (c & (iData_a[i] ^ iData_b[i]));
    end
    oData_C = c;
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl
//   Sequential 8x8 unsigned shift-add multiplier controller. Owns the
//   multiplicand (A), multiplier/low-product (Q) and accumulator (P)
//   registers and drives one shared 8-bit Adder for 8 iterations.
//
//   Handshake: a start request (iStart) is accepted on any rising edge where
//   the controller is in IDLE or DONE; operands are captured on that same
//   edge. oBusy is high in every RUN cycle. oDone pulses for exactly one
//   cycle when oProduct is updated. iStart while busy is ignored.
//
//   Ports:
//     iClk     : clock, rising edge
//     iRst     : synchronous reset, active high
//     iStart   : start request
//     iData_a  : multiplicand, captured on accepted start
//     iData_b  : multiplier, captured on accepted start
//     oBusy    : multiplication in progress
//     oDone    : one-cycle completion pulse
//     oProduct : last completed 16-bit product
module seq_mult_ctrl
  import seq_mult_ctrl_pkg::*;
(
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iStart,
  input  logic [WIDTH-1:0]   iData_a,
  input  logic [WIDTH-1:0]   iData_b,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oProduct
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_co;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign add_b = q_q[0] ? a_q : '0;

  Adder u_add (
    .oData   (add_sum),
    .oData_C (add_co),
    .iData_a (p_q),
    .iData_b (add_b),
    .iC      (1'b0)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      S_RUN: begin
        // Shift {carry, sum, Q} right by one: the sum LSB becomes a product
        // bit in Q and the carry becomes the new P MSB.
        p_d   = {add_co, add_sum[WIDTH-1:1]};
        q_d   = {add_sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d   = S_DONE;
          product_d = {p_d, q_d};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accepting a start from IDLE or DONE loads the operands on this edge;
    // from DONE this gives back-to-back operation.
    if ((state_q != S_RUN) && iStart) begin
      a_d     = iData_a;
      q_d     = iData_b;
      p_d     = '0;
      cnt_d   = '0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign oBusy    = (state_q == S_RUN);
  assign oDone    = (state_q == S_DONE);
  assign oProduct = product_q;

endmodule
